// File: rtl/bankroll_pkg.sv
// Shared types and helpers for the bankroll manager.
//   state_e      : settle FSM states
//   payout_multi : per-hit payout multiplier for a round of k bets
package bankroll_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEDUCT = 3'd1,
    ACCUM  = 3'd2,
    COMMIT = 3'd3,
    REJECT = 3'd4
  } state_e;

  localparam int unsigned PAYOUT_BASE_DEF = 8;

  // Spreading the stake over more bets lowers the payout of each hit.
  function automatic int unsigned payout_multi(input int unsigned k,
                                               input int unsigned base);
    return (k == 0) ? 0 : base / k;
  endfunction

endpackage

// File: rtl/bankroll_manager_if.sv
// Request/response bundle between the game FSM and the bankroll manager.
//   master : request side (req_valid, player_sel, bet_*, hit_mask, reload_req)
//   slave  : bankroll side (req_ready, done/err/round_win, payout, balances, flags)
interface bankroll_manager_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int MONEY_W     = 16,
  parameter int BET_W       = 16,
  parameter int MAX_BETS    = 4
);
  localparam int PSEL_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CNT_W  = $clog2(MAX_BETS + 1);

  logic                           req_valid;
  logic                           req_ready;
  logic [PSEL_W-1:0]              player_sel;
  logic [BET_W-1:0]               bet_amount;
  logic [CNT_W-1:0]               bet_count;
  logic [MAX_BETS-1:0]            hit_mask;
  logic                           reload_req;
  logic                           done;
  logic                           err;
  logic                           round_win;
  logic [MONEY_W+BET_W-1:0]       last_payout;
  logic [NUM_PLAYERS*MONEY_W-1:0] money_flat;
  logic [NUM_PLAYERS-1:0]         money_zero;
  logic [NUM_PLAYERS-1:0]         money_max;
  logic [15:0]                    round_count;

  modport master (
    output req_valid, player_sel, bet_amount, bet_count, hit_mask, reload_req,
    input  req_ready, done, err, round_win, last_payout, money_flat,
           money_zero, money_max, round_count
  );

  modport slave (
    input  req_valid, player_sel, bet_amount, bet_count, hit_mask, reload_req,
    output req_ready, done, err, round_win, last_payout, money_flat,
           money_zero, money_max, round_count
  );
endinterface

// File: rtl/bankroll_manager_sat_accum.sv
// Saturating add/subtract shared by the stake deduction and the win accumulation.
//   a_i, b_i : operands
//   sub_i    : 1 = a - b floored at 0, 0 = a + b
//   y_o      : result clamped to MAX
module bankroll_manager_sat_accum #(
  parameter int W   = 33,
  parameter int MAX = 10000
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] y_o
);
  logic [W:0]   sum;
  logic [W-1:0] raw;

  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    if (sub_i) raw = (a_i > b_i) ? (a_i - b_i) : '0;
    else       raw = (sum > (W+1)'(MAX)) ? W'(MAX) : sum[W-1:0];
    y_o = (raw > W'(MAX)) ? W'(MAX) : raw;
  end
endmodule

// File: rtl/bankroll_manager.sv
// Multi-player bankroll: settles one multi-bet round per accepted request,
// walking the hit mask one bet per cycle, and supports per-player reload.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : request/response bundle (slave side), see bankroll_manager_if
module bankroll_manager
  import bankroll_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int MONEY_W       = 16,
  parameter int BET_W         = 16,
  parameter int MAX_BETS      = 4,
  parameter int INITIAL_MONEY = 100,
  parameter int MAX_MONEY     = 10000,
  parameter int PAYOUT_BASE   = PAYOUT_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  bankroll_manager_if.slave  bus
);
  localparam int PSEL_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CNT_W  = $clog2(MAX_BETS + 1);
  localparam int PAY_W  = MONEY_W + BET_W;
  localparam int ACC_W  = PAY_W + 1;

  state_e state_q, state_d;

  logic [PSEL_W-1:0]                   sel_q;
  logic [BET_W-1:0]                    bet_q;
  logic [CNT_W-1:0]                    cnt_q, rem_q;
  logic [MAX_BETS-1:0]                 mask_q;
  logic [ACC_W-1:0]                    acc_q;
  logic [MONEY_W-1:0]                  start_q;
  logic [PAY_W-1:0]                    lp_q;
  logic [15:0]                         rc_q;
  logic                                done_q, err_q, win_q;
  logic [NUM_PLAYERS-1:0][MONEY_W-1:0] bal_q;
  logic [NUM_PLAYERS-1:0]              zero_q, max_q;

  logic accept, req_ok, reload, deduct, step, commit, rej, ready;
  logic [ACC_W-1:0]   op_a, op_b, op_y, addend;
  logic [MONEY_W-1:0] commit_val, wr_val;
  logic [PSEL_W-1:0]  wr_sel;
  logic               wr_en;

  assign req_ok = (bus.bet_count != '0)
               && (32'(bus.bet_count) <= 32'(MAX_BETS))
               && (32'(bus.player_sel) < 32'(NUM_PLAYERS));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reload  = 1'b0;
    deduct  = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    rej     = 1'b0;
    ready   = (state_q == IDLE) && !bus.reload_req;
    case (state_q)
      IDLE: begin
        // Reload wins over a same-cycle request; the request simply waits.
        if (bus.reload_req)
          reload = (32'(bus.player_sel) < 32'(NUM_PLAYERS));
        else if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = req_ok ? DEDUCT : REJECT;
        end
      end
      DEDUCT: begin deduct = 1'b1; state_d = ACCUM; end
      ACCUM: begin
        step = 1'b1;
        if (rem_q == CNT_W'(1)) state_d = COMMIT;
      end
      COMMIT: begin commit = 1'b1; state_d = IDLE; end
      REJECT: begin rej = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // mask_q is shifted each ACCUM cycle, so bit 0 is always the current bet.
  assign addend = mask_q[0]
                ? ACC_W'(bet_q) * ACC_W'(payout_multi(32'(cnt_q), 32'(PAYOUT_BASE)))
                : '0;
  assign op_a   = deduct ? ACC_W'(bal_q[sel_q]) : acc_q;
  assign op_b   = deduct ? ACC_W'(bet_q) : addend;

  bankroll_manager_sat_accum #(.W(ACC_W), .MAX(MAX_MONEY)) u_sat (
    .a_i(op_a), .b_i(op_b), .sub_i(deduct), .y_o(op_y)
  );

  assign commit_val = (acc_q > ACC_W'(MAX_MONEY)) ? MONEY_W'(MAX_MONEY)
                                                  : acc_q[MONEY_W-1:0];
  assign wr_en  = commit | reload;
  assign wr_sel = commit ? sel_q : bus.player_sel;
  assign wr_val = commit ? commit_val : MONEY_W'(INITIAL_MONEY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q   <= '0;
      bet_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      start_q <= '0;
      lp_q    <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      win_q   <= 1'b0;
      zero_q  <= '0;
      max_q   <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) bal_q[p] <= MONEY_W'(INITIAL_MONEY);
    end else begin
      done_q <= commit | rej;
      err_q  <= rej;
      if (accept) begin
        sel_q  <= bus.player_sel;
        bet_q  <= bus.bet_amount;
        cnt_q  <= bus.bet_count;
        rem_q  <= bus.bet_count;
        mask_q <= bus.hit_mask;
        lp_q   <= '0;
      end
      if (deduct) begin
        acc_q   <= op_y;
        start_q <= bal_q[sel_q];
      end
      if (step) begin
        acc_q  <= op_y;
        lp_q   <= lp_q + PAY_W'(addend);
        rem_q  <= rem_q - CNT_W'(1);
        mask_q <= mask_q >> 1;
      end
      if (commit) begin
        rc_q  <= rc_q + 16'd1;
        win_q <= commit_val > start_q;
      end
      if (rej) win_q <= 1'b0;
      if (wr_en) begin
        bal_q[wr_sel]  <= wr_val;
        zero_q[wr_sel] <= (wr_val == '0);
        max_q[wr_sel]  <= (wr_val >= MONEY_W'(MAX_MONEY));
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.round_win   = win_q;
  assign bus.last_payout = lp_q;
  assign bus.money_flat  = bal_q;
  assign bus.money_zero  = zero_q;
  assign bus.money_max   = max_q;
  assign bus.round_count = rc_q;
endmodule

// File: tb/tb_bankroll_manager.sv
// Bench for bankroll_manager: directed rounds, a per-cycle compare process
// against an arithmetic model of the rules, and literal expectations.
module tb_bankroll_manager;
  localparam int NP = 2, MW = 16, BW = 16, MB = 4, INIT = 100, MAXM = 10000;
  localparam int PW = 1, CW = $clog2(MB + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  bankroll_manager_if #(.NUM_PLAYERS(NP), .MONEY_W(MW), .BET_W(BW), .MAX_BETS(MB)) bif ();

  bankroll_manager #(
    .NUM_PLAYERS(NP), .MONEY_W(MW), .BET_W(BW), .MAX_BETS(MB),
    .INITIAL_MONEY(INIT), .MAX_MONEY(MAXM), .PAYOUT_BASE(8)
  ) dut (.clk(clk), .rst(rst), .bus(bif.slave));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  bit run = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // request/reload notices posted by the stimulus
  int acc_id = 0, a_p, a_bet, a_cnt, a_mask, a_due;
  bit a_bad;
  int rl_id = 0, rl_p;
  // model state, owned by the compare process
  int fin_id = 0, seen_rl = 0;
  int m_bal[NP];
  int m_rc = 0;
  longint m_lp = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint bal(input int p);
    return longint'(bif.money_flat[p*MW +: MW]);
  endfunction

  // Round outcome straight from the rules: stake off (floored at 0), each
  // hit pays bet*(8/count), final balance capped at MAXM.
  function automatic void model_round(input int b, input int bet, input int cnt,
                                      input int mask, output int nb, output longint pay);
    longint acc;
    acc = (b > bet) ? b - bet : 0;
    pay = 0;
    for (int i = 0; i < cnt; i++)
      if (mask[i]) pay += longint'(bet) * (8 / cnt);
    acc += pay;
    nb = (acc > MAXM) ? MAXM : int'(acc);
  endfunction

  always @(negedge clk) begin
    bit e_done, busy;
    int nb;
    longint pay;
    if (!rst) begin
      for (int p = 0; p < NP; p++) m_bal[p] = INIT;
      m_rc = 0; m_lp = 0; fin_id = acc_id; seen_rl = rl_id;
    end else if (run) begin
      if (rl_id != seen_rl) begin
        if (rl_p < NP) m_bal[rl_p] = INIT;
        seen_rl = rl_id;
      end
      e_done = (acc_id != fin_id) && (cyc == a_due);
      if (e_done) begin
        fin_id = acc_id;
        if (a_bad) begin
          chk("err_on_reject", bif.err, 1);
          m_lp = 0;
        end else begin
          model_round(m_bal[a_p], a_bet, a_cnt, a_mask, nb, pay);
          chk("err_on_settle", bif.err, 0);
          chk("round_win", bif.round_win, nb > m_bal[a_p]);
          m_bal[a_p] = nb;
          m_rc = (m_rc + 1) % 65536;
          m_lp = pay;
        end
      end
      busy = (acc_id != fin_id);
      chk("done", bif.done, e_done);
      chk("req_ready", bif.req_ready, !busy && !bif.reload_req);
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("balance[%0d]", p), bal(p), m_bal[p]);
        chk($sformatf("money_zero[%0d]", p), bif.money_zero[p], m_bal[p] == 0);
        chk($sformatf("money_max[%0d]", p), bif.money_max[p], m_bal[p] >= MAXM);
      end
      chk("round_count", bif.round_count, m_rc);
      if (!busy) chk("last_payout", bif.last_payout, m_lp);
    end
  end

  task automatic wait_round();
    int g = 0;
    while (acc_id != fin_id && g < 40) begin @(posedge clk); g++; end
    #1;
    if (acc_id != fin_id) begin
      n_chk++; n_fail++;
      $display("FAIL round_timeout: got busy after %0d cycles, expected done", g);
    end
  endtask

  task automatic send(input int p, input int bet, input int cnt, input int mask,
                      input bit wait_done);
    bif.player_sel = PW'(p);
    bif.bet_amount = BW'(bet);
    bif.bet_count  = CW'(cnt);
    bif.hit_mask   = MB'(mask);
    bif.req_valid  = 1'b1;
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    a_p = p; a_bet = bet; a_cnt = cnt; a_mask = mask;
    a_bad = (cnt == 0) || (cnt > MB) || (p >= NP);
    a_due = cyc + (a_bad ? 1 : cnt + 2);
    acc_id++;
    if (wait_done) wait_round();
  endtask

  task automatic reload(input int p, input bit with_req);
    bif.player_sel = PW'(p);
    bif.reload_req = 1'b1;
    bif.req_valid  = with_req;
    bif.bet_amount = BW'(10);
    bif.bet_count  = CW'(1);
    bif.hit_mask   = MB'(1);
    #1 chk("reload_ready_low", bif.req_ready, 0);
    @(posedge clk);
    rl_p = p; rl_id++;
    #1;
    bif.reload_req = 1'b0;
    bif.req_valid  = 1'b0;
  endtask

  initial begin
    bif.req_valid = 0; bif.reload_req = 0; bif.player_sel = '0;
    bif.bet_amount = '0; bif.bet_count = '0; bif.hit_mask = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_p0", bal(0), 100);
    chk("rst_p1", bal(1), 100);
    chk("rst_zero", bif.money_zero, 0);
    chk("rst_max", bif.money_max, 0);
    chk("rst_rc", bif.round_count, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_lp", bif.last_payout, 0);
    rst = 1'b1; run = 1'b1;
    @(posedge clk); #1;

    send(0, 10, 1, 'b0001, 1);
    chk("t1_p0", bal(0), 170);
    chk("t1_lp", bif.last_payout, 80);
    chk("t1_p1", bal(1), 100);

    reload(0, 1);
    chk("reload_p0", bal(0), 100);
    chk("reload_rc", bif.round_count, 1);

    send(0, 10, 3, 'b0101, 1);
    chk("t2_p0", bal(0), 130);
    chk("t2_lp", bif.last_payout, 40);

    send(1, 150, 2, 'b0000, 1);
    chk("t3_p1", bal(1), 0);
    chk("t3_zero1", bif.money_zero[1], 1);

    send(0, 130, 1, 'b0001, 1);
    send(0, 1040, 1, 'b0001, 1);
    send(0, 334, 3, 'b0111, 1);
    chk("t4_p0_9990", bal(0), 9990);
    send(0, 2000, 1, 'b0001, 1);
    chk("t4_p0_clamp", bal(0), 10000);
    chk("t4_max0", bif.money_max[0], 1);
    chk("t4_lp", bif.last_payout, 16000);
    chk("t4_rc", bif.round_count, 7);

    send(0, 10, 0, 'b0001, 1);
    send(0, 10, 5, 'b1111, 1);
    chk("rej_p0", bal(0), 10000);
    chk("rej_rc", bif.round_count, 7);
    chk("rej_lp", bif.last_payout, 0);

    send(1, 5, 1, 'b0001, 1);
    chk("zero_bal_p1", bal(1), 40);

    reload(1, 0);
    chk("reload_p1", bal(1), 100);

    send(0, 50, 4, 'b1111, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (8) @(posedge clk); #1;
    chk("abort_p0", bal(0), 100);
    chk("abort_rc", bif.round_count, 0);
    chk("abort_done", bif.done, 0);

    send(1, 20, 2, 'b0010, 1);
    chk("after_p1", bal(1), 160);
    chk("after_lp", bif.last_payout, 80);
    chk("after_rc", bif.round_count, 1);

    repeat (2) @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected end of stimulus");
    $fatal(1);
  end
endmodule
